// File: rtl/ahb_apb_bridge.sv
// AHB-Lite responder that replays every accepted AHB beat as one APB4 transfer.
// Define AHB_APB_TIMEOUT_EN to enable the ACCESS-phase watchdog (TIMEOUT_CYCLES).
module ahb_apb_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSELx,
  input  logic [ADDRESS_WIDTH-1:0]  HADDR,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [1:0]                HTRANS,
  input  logic [3:0]                HPROT,
  input  logic                      HREADY,
  input  logic [DATA_WIDTH-1:0]     HWDATA,
  output logic [DATA_WIDTH-1:0]     HRDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [ADDRESS_WIDTH-1:0]  PADDR,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic [DATA_WIDTH-1:0]     PWDATA,
  output logic [DATA_WIDTH/8-1:0]   PSTRB,
  output logic [2:0]                PPROT,
  input  logic [DATA_WIDTH-1:0]     PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDAT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        size_q;
  logic              accept_c;
  logic              illegal_c;
  logic              timeout_c;
  logic [STRB_W-1:0] strb_c;
  logic              unused_bits;

  // HTRANS[0] only separates NONSEQ/SEQ and BUSY/IDLE, which are treated alike here.
  assign unused_bits = ^{HTRANS[0], HPROT[3:2]};

  assign accept_c  = HSELx & HREADY & HTRANS[1] &
                     ((state == ST_IDLE) | (state == ST_ERR2));
  assign illegal_c = (HSIZE > 3'd2) |
                     ((HSIZE == 3'd1) & HADDR[0]) |
                     ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  // Byte-lane strobes from the latched size and low address bits.
  always_comb begin
    strb_c = '1;
    case (size_q)
      3'd0:    strb_c = STRB_W'(1) << PADDR[1:0];
      3'd1:    strb_c = STRB_W'(3) << {PADDR[1], 1'b0};
      default: strb_c = '1;
    endcase
  end

`ifdef AHB_APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts ACCESS cycles with PREADY low; cleared while in SETUP, i.e. on ACCESS entry.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tmo_cnt <= '0;
    end else if (state == ST_SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ST_ACCESS) && !PREADY) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign timeout_c = (state == ST_ACCESS) && !PREADY &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_c      = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept_c) begin
          if (illegal_c)   state_nxt = ST_ERR1;
          else if (HWRITE) state_nxt = ST_WDAT;
          else             state_nxt = ST_SETUP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WDAT:  state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY)         state_nxt = PSLVERR ? ST_ERR1 : ST_IDLE;
        else if (timeout_c) state_nxt = ST_ERR1;
      end
      ST_ERR1:  state_nxt = ST_ERR2;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered bus outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      size_q    <= 3'd0;
      HRDATA    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= 3'b000;
    end else begin
      state     <= state_nxt;
      HREADYOUT <= (state_nxt == ST_IDLE) || (state_nxt == ST_ERR2);
      HRESP     <= (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
      PSEL      <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
      PENABLE   <= (state_nxt == ST_ACCESS);

      // Illegal transfers leave the APB side untouched.
      if (accept_c && !illegal_c) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
        PSTRB  <= '0;
        size_q <= HSIZE;
      end

      if (state == ST_WDAT) begin
        PWDATA <= HWDATA;
        PSTRB  <= strb_c;
      end

      if ((state == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
        HRDATA <= PRDATA;
      end else if (timeout_c) begin
        HRDATA <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: directed AHB transfers, APB completer model,
// separate AHB-completion and APB-transfer monitors that pop expected responses.
module tb_ahb_apb_bridge;

  logic        HCLK;
  logic        HRESET;
  logic        HSELx;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  // Single subordinate on the bus: the muxed ready is our own ready.
  assign HREADY = HREADYOUT;

  ahb_apb_bridge #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSELx    (HSELx),
    .HADDR    (HADDR),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HTRANS   (HTRANS),
    .HPROT    (HPROT),
    .HREADY   (HREADY),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PPROT    (PPROT),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          resp;
    int          waits;
  } ahb_exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } apb_exp_t;

  ahb_exp_t    ahb_q[$];
  apb_exp_t    apb_q[$];
  int          checks;
  int          errors;
  int          setup_seen;
  int          setup_exp;
  int          apb_wait;
  logic [31:0] apb_rdata;
  bit          apb_err;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // APB completer: apb_wait ACCESS cycles with PREADY low, then completes.
  initial begin : completer
    int acc_cnt;
    acc_cnt = 0;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    forever begin
      @(negedge HCLK);
      if (!HRESET && PSEL && PENABLE) begin
        if (acc_cnt < apb_wait) begin
          PREADY  = 1'b0;
          PSLVERR = 1'b0;
          acc_cnt++;
        end else begin
          PREADY  = 1'b1;
          PRDATA  = apb_rdata;
          PSLVERR = apb_err;
        end
      end else begin
        acc_cnt = 0;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
      end
    end
  end

  // APB monitor: checks each completed APB transfer against the expected queue.
  initial begin : apb_mon
    apb_exp_t e;
    forever begin
      @(negedge HCLK);
      #1;
      if (!HRESET) begin
        if (PSEL && !PENABLE) setup_seen++;
        if (PSEL && PENABLE && PREADY) begin
          if (apb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL apb_unexpected: got transfer at PADDR 0x%08h, required none", PADDR);
          end else begin
            e = apb_q.pop_front();
            check({e.name, "_paddr"}, PADDR, e.addr);
            check({e.name, "_pwrite"}, 32'(PWRITE), 32'(e.write));
            check({e.name, "_pstrb"}, 32'(PSTRB), 32'(e.strb));
            check({e.name, "_pprot"}, 32'(PPROT), 32'(e.prot));
            if (e.write) check({e.name, "_pwdata"}, PWDATA, e.wdata);
          end
        end
      end
    end
  end

  // AHB monitor: tracks the data phase of each accepted transfer and checks its completion.
  initial begin : ahb_mon
    ahb_exp_t e;
    bit       pending;
    bit       prev_resp;
    int       waits;
    pending   = 1'b0;
    prev_resp = 1'b0;
    waits     = 0;
    forever begin
      @(negedge HCLK);
      #1;
      if (HRESET) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (HREADYOUT) begin
            pending = 1'b0;
            if (ahb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL ahb_unexpected: got completion HRESP=%0d, required none", HRESP);
            end else begin
              e = ahb_q.pop_front();
              check({e.name, "_resp"}, 32'({prev_resp, HRESP}), e.resp ? 32'd3 : 32'd0);
              check({e.name, "_waits"}, 32'(waits), 32'(e.waits));
              if (e.chk_rdata) check({e.name, "_hrdata"}, HRDATA, e.rdata);
            end
          end else begin
            waits++;
          end
        end
        if (HSELx && HTRANS[1] && HREADYOUT) begin
          pending = 1'b1;
          waits   = 0;
        end
      end
      prev_resp = HRESP;
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge HCLK);
      if (HREADYOUT) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: got HREADYOUT low for 300 cycles, required high");
    end
  endtask

  // Issues one AHB transfer; the next call overlaps its address phase with this completion.
  task automatic ahb_xfer(input string name, input logic [31:0] addr, input bit write,
                          input logic [2:0] size, input logic [3:0] prot, input logic [31:0] wdata,
                          input int pwait, input logic [31:0] prdata, input bit perr,
                          input bit exp_resp, input int exp_waits, input bit exp_apb,
                          input logic [3:0] exp_strb, input logic [2:0] exp_prot,
                          input bit chk_rdata, input logic [31:0] exp_rdata);
    ahb_exp_t a;
    apb_exp_t p;
    wait_ready();
    HSELx     = 1'b1;
    HTRANS    = 2'b10;
    HADDR     = addr;
    HWRITE    = write;
    HSIZE     = size;
    HPROT     = prot;
    apb_wait  = pwait;
    apb_rdata = prdata;
    apb_err   = perr;
    a.name = name; a.rdata = exp_rdata; a.chk_rdata = chk_rdata;
    a.resp = exp_resp; a.waits = exp_waits;
    ahb_q.push_back(a);
    if (exp_apb) begin
      p.name = name; p.addr = addr; p.write = write; p.wdata = wdata;
      p.strb = exp_strb; p.prot = exp_prot;
      apb_q.push_back(p);
      setup_exp++;
    end
    @(negedge HCLK);
    HSELx  = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wdata;
  endtask

  initial begin : stim
    bit found;
    checks = 0; errors = 0; setup_seen = 0; setup_exp = 0;
    apb_wait = 0; apb_rdata = 32'h0; apb_err = 1'b0;
    HRESET = 1'b1; HSELx = 1'b0; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd0;
    HTRANS = 2'b00; HPROT = 4'h0; HWDATA = 32'h0;
    repeat (3) @(negedge HCLK);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_psel", 32'({PSEL, PENABLE}), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pstrb_pprot", 32'({PSTRB, PPROT, PWRITE}), 32'd0);
    HRESET = 1'b0;

    //        name     addr          wr  sz    prot   wdata         wait prdata        err rsp wt apb strb     prot    chk rdata
    ahb_xfer("rd104",  32'h0000_0104, 0, 3'd2, 4'h3, 32'h0,          0, 32'hDEAD_BEEF, 0, 0, 2, 1, 4'b0000, 3'b001, 1, 32'hDEAD_BEEF);
    ahb_xfer("wrb203", 32'h0000_0203, 1, 3'd0, 4'h0, 32'hAA00_0000,  0, 32'h0,         0, 0, 3, 1, 4'b1000, 3'b100, 0, 32'h0);
    ahb_xfer("wrh302", 32'h0000_0302, 1, 3'd1, 4'h2, 32'h1234_0000,  0, 32'h0,         0, 0, 3, 1, 4'b1100, 3'b101, 0, 32'h0);
    ahb_xfer("wrw010", 32'h0000_0010, 1, 3'd2, 4'h1, 32'h0BAD_F00D,  0, 32'h0,         0, 0, 3, 1, 4'b1111, 3'b000, 0, 32'h0);
    ahb_xfer("rderr",  32'h0000_0020, 0, 3'd2, 4'h1, 32'h0,          5, 32'h1111_2222, 1, 1, 8, 1, 4'b0000, 3'b000, 0, 32'h0);
    ahb_xfer("wrmis",  32'h0000_0002, 1, 3'd2, 4'h1, 32'hFFFF_FFFF,  0, 32'h0,         0, 1, 1, 0, 4'b0000, 3'b000, 0, 32'h0);
    ahb_xfer("rdb2b",  32'h0000_0040, 0, 3'd2, 4'h1, 32'h0,          0, 32'h1234_5678, 0, 0, 2, 1, 4'b0000, 3'b000, 1, 32'h1234_5678);
    ahb_xfer("rdhmis", 32'h0000_0041, 0, 3'd1, 4'h1, 32'h0,          0, 32'h0,         0, 1, 1, 0, 4'b0000, 3'b000, 0, 32'h0);
    ahb_xfer("rdsz3",  32'h0000_0000, 0, 3'd3, 4'h1, 32'h0,          0, 32'h0,         0, 1, 1, 0, 4'b0000, 3'b000, 0, 32'h0);
    ahb_xfer("rdwait", 32'h0000_0080, 0, 3'd2, 4'h1, 32'h0,          2, 32'hCAFE_F00D, 0, 0, 4, 1, 4'b0000, 3'b000, 1, 32'hCAFE_F00D);

    // BUSY and IDLE beats to a selected bridge are ignored with zero wait.
    wait_ready();
    HSELx = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_0600;
    @(negedge HCLK);
    check("busy_ready", 32'({HREADYOUT, PSEL}), 32'b10);
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("idle_ready", 32'({HREADYOUT, PSEL}), 32'b10);
    HSELx = 1'b0;

    // Reset while the APB completer is stalling in ACCESS.
    wait_ready();
    HSELx = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0300; HWRITE = 1'b0; HSIZE = 3'd2;
    HPROT = 4'h1; apb_wait = 50;
    setup_exp++;
    @(negedge HCLK);
    HSELx = 1'b0; HTRANS = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (PSEL && PENABLE) begin
        found = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    check("rst_mid_access_seen", 32'(found), 32'd1);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    check("rst_mid_psel_penable", 32'({PSEL, PENABLE}), 32'd0);
    check("rst_mid_hreadyout", 32'(HREADYOUT), 32'd1);
    @(negedge HCLK);
    HRESET = 1'b0;
    ahb_xfer("rdpost", 32'h0000_0304, 0, 3'd2, 4'h1, 32'h0,          0, 32'h0F0F_0F0F, 0, 0, 2, 1, 4'b0000, 3'b000, 1, 32'h0F0F_0F0F);

`ifdef AHB_APB_TIMEOUT_EN
    ahb_xfer("rdtmo",  32'h0000_0500, 0, 3'd2, 4'h1, 32'h0,       1000, 32'h5555_5555, 0, 1, 10, 0, 4'b0000, 3'b000, 1, 32'h0);
    setup_exp++;
    wait_ready();
    check("tmo_psel", 32'({PSEL, PENABLE}), 32'd0);
`endif

    wait_ready();
    repeat (3) @(negedge HCLK);
    check("ahb_queue_empty", 32'(ahb_q.size()), 32'd0);
    check("apb_queue_empty", 32'(apb_q.size()), 32'd0);
    check("setup_count", 32'(setup_seen), 32'(setup_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-Lite responder that terminates AHB transfers from the bus fabric and replays each one as a single APB4 transfer to one APB completer. It occupies one `HSEL` slot behind the address decoder, and its `HREADYOUT`/`HRESP`/`HRDATA` feed the response mux like any other subordinate. Every AHB beat, including each beat of a burst, becomes one APB transfer. Wait states are inserted on the AHB side until the APB completer responds.

## Interface
Parameters:
- `DATA_WIDTH`, 32: AHB and APB data width; only 32 is supported.
- `ADDRESS_WIDTH`, 32: width of `HADDR`; `PADDR` carries the full latched address.
- `TIMEOUT_CYCLES`, 256: ACCESS-phase watchdog limit; used only with `AHB_APB_TIMEOUT_EN`.

Ports:
- `HCLK`  in  1  clock; all logic on the rising edge.
- `HRESET`  in  1  synchronous reset, active-high.
- `HSELx`  in  1  subordinate select from the decoder.
- `HADDR`  in  ADDRESS_WIDTH  transfer address.
- `HWRITE`  in  1  1 = write.
- `HSIZE`  in  3  transfer size.
- `HTRANS`  in  2  IDLE/BUSY/NONSEQ/SEQ.
- `HPROT`  in  4  protection attributes.
- `HREADY`  in  1  bus-wide ready (muxed).
- `HWDATA`  in  DATA_WIDTH  write data, data phase.
- `HRDATA`  out  DATA_WIDTH  read data, registered.
- `HREADYOUT`  out  1  this subordinate's ready.
- `HRESP`  out  1  0 = OKAY, 1 = ERROR.
- `PADDR`  out  ADDRESS_WIDTH; `PWRITE`  out  1; `PSEL`  out  1; `PENABLE`  out  1.
- `PWDATA`  out  DATA_WIDTH; `PSTRB`  out  DATA_WIDTH/8; `PPROT`  out  3.
- `PRDATA`  in  DATA_WIDTH; `PREADY`  in  1; `PSLVERR`  in  1.

## Operation
- Accept condition: `HSELx & HREADY & HTRANS[1]`, evaluated only in IDLE or ERR2. On accept, latch `HADDR`, `HWRITE`, `HSIZE`, `HPROT`.
- BUSY and IDLE `HTRANS` are ignored and get a zero-wait OKAY. SEQ is handled exactly like NONSEQ. `HMASTLOCK` is not used.
- Illegal size (`HSIZE>2`) or a misaligned address (halfword with `HADDR[0]=1`, word with `HADDR[1:0]!=0`): go directly to ERR1 and issue no APB access.
- States:
  - IDLE
  - WDAT: writes only; capture `HWDATA` into `PWDATA` and build `PSTRB` from latched `HSIZE`/`HADDR[1:0]`.
  - SETUP: `PSEL=1`, `PENABLE=0`.
  - ACCESS: `PSEL=1`, `PENABLE=1`.
  - ERR1: `HRESP=1`, `HREADYOUT=0`.
  - ERR2: `HRESP=1`, `HREADYOUT=1`.
- Transitions:
  - IDLE/ERR2 + accept: write → WDAT; read → SETUP; illegal → ERR1.
  - WDAT → SETUP → ACCESS.
  - ACCESS & !PREADY: stay in ACCESS.
  - ACCESS & PREADY & !PSLVERR: → IDLE; on that edge, `HRDATA<=PRDATA` for reads.
  - ACCESS & PREADY & PSLVERR: → ERR1.
  - ERR1 → ERR2 → IDLE, unless a new transfer is accepted in ERR2.
- `HREADYOUT` is 1 only in IDLE and ERR2. `HRESP` is 1 only in ERR1 and ERR2.
- `PPROT = {~HPROT[0], 1'b0, HPROT[1]}`.
- `PSTRB` is all-zero for reads. For writes, byte/halfword/word lanes are selected by `HADDR[1:0]`.
- `PADDR`, `PWRITE`, `PWDATA`, `PSTRB`, `PPROT` hold stable from SETUP until the ACCESS exit.
- Reset values: all outputs 0 except `HREADYOUT=1`. State returns to IDLE.
- Reset asserted mid-transfer: on the next edge `PSEL`/`PENABLE` drop to 0 and the in-flight transfer is discarded.

## Timing
- Accept at edge 0 (address phase in cycle T0).
- Read, `PREADY` tied high: T1 SETUP, T2 ACCESS, T3 IDLE with `HREADYOUT=1` and `HRDATA` valid. That is 2 AHB wait states.
- Write, `PREADY` tied high: T1 WDAT, T2 SETUP, T3 ACCESS, T4 IDLE. That is 3 wait states.
- Each cycle `PREADY` is low in ACCESS adds one wait state.
- Error response: ERR1 and ERR2 each last one cycle, with `HREADYOUT` rising in ERR2.
- Back-to-back transfers: the next address phase is accepted in the completion cycle (IDLE or ERR2), so there are no idle gaps on APB beyond SETUP.

## Configuration
- `AHB_APB_TIMEOUT_EN` defined:
  - A counter runs in ACCESS and clears on entry.
  - If `PREADY` is still low after `TIMEOUT_CYCLES` ACCESS cycles, drop `PSEL`/`PENABLE`, return `HRDATA=0`, and go to ERR1.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Undefined: no counter; the bridge waits in ACCESS indefinitely.

## Test plan
- Read at 0x0000_0104, `PRDATA=0xDEADBEEF`, `PREADY=1` → `PADDR=0x104`, `PSTRB=0`, `HREADYOUT` low for 2 cycles, `HRDATA=0xDEADBEEF`, `HRESP=0`.
- Byte write to 0x0000_0203, `HWDATA=0xAA000000` → `PSTRB=4'b1000`, `PWDATA=0xAA000000`, `PWRITE=1`, 3 wait states.
- Read with `PREADY` low for 5 ACCESS cycles, then `PSLVERR=1` → 2+5 wait states, then the two-cycle ERROR response (`HREADYOUT` 0 then 1, `HRESP=1` both cycles).
- Word write to 0x0000_0002 → ERR1/ERR2 response, `PSEL` never asserted.
- Reset asserted in ACCESS → `PSEL=0`, `PENABLE=0`, `HREADYOUT=1` after the next edge. A following read then completes normally.
- With `AHB_APB_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, `PREADY` stuck low → ERROR response after 8 ACCESS cycles and `PSEL` deasserted.
